// File: rtl/duc_pkg.sv
// Shared definitions for the DUC sample feeder: FSM encoding, CIC rate and I/Q packing.
package duc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int DUC_RATE_LOG2 = 7;

  // Packed host word: I in the upper half, Q in the lower half.
  localparam int I_MSB = 31;
  localparam int Q_MSB = 15;

endpackage

// File: rtl/duc_sample_feeder_if.sv
// Host streaming bus into the sample feeder FIFO.
interface duc_sample_feeder_if;
  // A word transfers on every rising clk edge where s_valid && s_ready; the
  // master holds s_data stable while s_valid is high and s_ready is low.
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/duc_sample_feeder_fifo.sv
// Single-clock FIFO with registered storage; a pushed word is visible from the next cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/duc_sample_feeder.sv
// Holds one I/Q pair per CIC input period, fed from a FIFO with priming and underrun recovery.
// Optional sticky underrun counter output enabled by defining DUC_FEEDER_UNDERRUN_CNT_EN.
module duc_sample_feeder
  import duc_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 8,
  parameter int RATE_LOG2 = DUC_RATE_LOG2
) (
  input  logic                   clk,
  input  logic                   reset,
  duc_sample_feeder_if.slave     s,
  input  logic                   enable,
  input  logic                   underrun_clr,
  output logic signed [15:0]     out_i,
  output logic signed [15:0]     out_q,
  output logic                   out_strobe,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underrun,
`ifdef DUC_FEEDER_UNDERRUN_CNT_EN
  output logic [15:0]            underrun_cnt,
`endif
  output state_t                 dbg_state
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_LVL_W = LW'(PRIME_LVL);

  logic [RATE_LOG2-1:0] cnt_q;
  state_t               state_q;
  logic [15:0]          i_q, q_q;
  logic                 strobe_q, underrun_q;
  logic                 tick, push, pop, ur_hit, empty, full;
  logic [31:0]          head;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .wdata_i (s.s_data),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (fifo_level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign s.s_ready = !full;
  assign push      = s.s_valid && !full;
  assign tick      = &cnt_q;

  // Pops and underruns only ever happen on the tick edge, so the held sample never tears.
  assign pop    = enable && tick &&
                  (((state_q == ST_RUN) && !empty) ||
                   ((state_q == ST_PRIME) && (fifo_level >= PRIME_LVL_W)));
  assign ur_hit = enable && tick && (state_q == ST_RUN) && empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      i_q        <= '0;
      q_q        <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
      strobe_q <= tick;
      if (tick) begin
        i_q <= pop ? head[I_MSB -: 16] : 16'h0000;
        q_q <= pop ? head[Q_MSB -: 16] : 16'h0000;
      end
      if (!enable) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE:  state_q <= ST_PRIME;
          ST_PRIME: if (pop) state_q <= ST_RUN;
          ST_RUN:   if (ur_hit) state_q <= ST_PRIME;
          default:  state_q <= ST_IDLE;
        endcase
      end
      if (ur_hit)            underrun_q <= 1'b1;
      else if (underrun_clr) underrun_q <= 1'b0;
    end
  end

`ifdef DUC_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ur_cnt_q <= '0;
    end else if (ur_hit) begin
      if (underrun_clr)              ur_cnt_q <= 16'd1;
      else if (ur_cnt_q != 16'hFFFF) ur_cnt_q <= ur_cnt_q + 16'd1;
    end else if (underrun_clr) begin
      ur_cnt_q <= '0;
    end
  end

  assign underrun_cnt = ur_cnt_q;
`endif

  assign out_i      = i_q;
  assign out_q      = q_q;
  assign out_strobe = strobe_q;
  assign underrun   = underrun_q;
  assign dbg_state  = state_q;
endmodule
